// File: rtl/prbs8_checker.sv
// Self-synchronising checker for the 8-bit Fibonacci LFSR (taps 7,5,4,3): lock, error count, zero-word flag.
// Optional PRBS8_CHK_ERR_SAT_EN: error counter saturates instead of wrapping.
module prbs8_checker #(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3,
    parameter int ERR_W        = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       I,
    input  logic             I_VALID,
    input  logic             CLR_ERR,
    output logic             LOCKED,
    output logic             ERR_PULSE,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             ZERO_DET
);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_LIM   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_LIM = 4'(UNLOCK_COUNT);

    state_t           r_state;
    logic [7:0]       r_ref;
    logic [3:0]       r_match_cnt;
    logic [3:0]       r_miss_cnt;
    logic             r_locked;
    logic             r_err_pulse;
    logic [ERR_W-1:0] r_err_cnt;
    logic             r_zero_det;

    state_t           w_state_next;
    logic [7:0]       w_ref_next;
    logic [3:0]       w_match_next;
    logic [3:0]       w_miss_next;
    logic             w_err;
    logic [7:0]       w_pred;
    logic             w_is_match;
    logic             w_is_zero;
    logic [3:0]       w_match_inc;
    logic [3:0]       w_miss_inc;

    assign w_pred      = {r_ref[7] ^ r_ref[5] ^ r_ref[4] ^ r_ref[3], r_ref[7:1]};
    assign w_is_match  = (I == w_pred);
    assign w_is_zero   = (I == 8'h00);
    assign w_match_inc = r_match_cnt + 4'd1;
    assign w_miss_inc  = r_miss_cnt + 4'd1;

    always_comb begin
        w_state_next = r_state;
        w_ref_next   = r_ref;
        w_match_next = r_match_cnt;
        w_miss_next  = r_miss_cnt;
        w_err        = 1'b0;
        if (I_VALID) begin
            case (r_state)
                S_SEARCH: begin
                    if (!w_is_zero) begin
                        w_ref_next   = I;
                        w_match_next = 4'd0;
                        w_state_next = S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    w_ref_next = I;
                    if (w_is_match) begin
                        w_match_next = w_match_inc;
                        if (w_match_inc == LOCK_LIM) begin
                            w_state_next = S_LOCKED;
                            w_miss_next  = 4'd0;
                        end
                    end else if (w_is_zero) begin
                        w_match_next = 4'd0;
                        w_state_next = S_SEARCH;
                    end else begin
                        w_match_next = 4'd0;
                    end
                end
                S_LOCKED: begin
                    if (w_is_match) begin
                        w_miss_next = 4'd0;
                        w_ref_next  = I;
                    end else begin
                        // Flywheel: keep the local sequence running rather than adopting the bad word.
                        w_err       = 1'b1;
                        w_miss_next = w_miss_inc;
                        w_ref_next  = w_pred;
                        if (w_miss_inc == UNLOCK_LIM) begin
                            w_state_next = S_SEARCH;
                        end
                    end
                end
                default: begin
                    w_state_next = S_SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_SEARCH;
            r_ref       <= 8'h00;
            r_match_cnt <= 4'd0;
            r_miss_cnt  <= 4'd0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
            r_zero_det  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ref       <= w_ref_next;
            r_match_cnt <= w_match_next;
            r_miss_cnt  <= w_miss_next;
            r_locked    <= (w_state_next == S_LOCKED);
            r_err_pulse <= w_err;
            if (I_VALID) begin
                r_zero_det <= w_is_zero;
            end
            if (CLR_ERR) begin
                r_err_cnt <= '0;
            end else if (w_err) begin
`ifdef PRBS8_CHK_ERR_SAT_EN
                if (r_err_cnt != {ERR_W{1'b1}}) begin
                    r_err_cnt <= r_err_cnt + ERR_W'(1);
                end
`else
                r_err_cnt <= r_err_cnt + ERR_W'(1);
`endif
            end
        end
    end

    assign LOCKED    = r_locked;
    assign ERR_PULSE = r_err_pulse;
    assign ERR_CNT   = r_err_cnt;
    assign ZERO_DET  = r_zero_det;

endmodule

// File: tb/tb_prbs8_checker.sv
// Directed bench for prbs8_checker: default instance plus a narrow-counter instance for wrap/saturation.
module tb_prbs8_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  d1_i,  d2_i;
    logic        d1_v,  d2_v;
    logic        d1_clr, d2_clr;
    logic        d1_locked, d1_pulse, d1_zd;
    logic [15:0] d1_cnt;
    logic        d2_locked, d2_pulse, d2_zd;
    logic [1:0]  d2_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Correct stream: 80 C0 E0 70 38 9C CE 67 B3 D9 EC F6 (hand-computed successors)
    logic [7:0] seq [0:11];

    always #5 clk = ~clk;

    prbs8_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(3), .ERR_W(16)) u_dut (
        .CLK(clk), .RESET(rst), .I(d1_i), .I_VALID(d1_v), .CLR_ERR(d1_clr),
        .LOCKED(d1_locked), .ERR_PULSE(d1_pulse), .ERR_CNT(d1_cnt), .ZERO_DET(d1_zd)
    );

    prbs8_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(15), .ERR_W(2)) u_dut_sat (
        .CLK(clk), .RESET(rst), .I(d2_i), .I_VALID(d2_v), .CLR_ERR(d2_clr),
        .LOCKED(d2_locked), .ERR_PULSE(d2_pulse), .ERR_CNT(d2_cnt), .ZERO_DET(d2_zd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step1(input logic v, input logic [7:0] w, input logic clr);
        d1_v = v; d1_i = w; d1_clr = clr;
        @(posedge clk); #1;
        d1_v = 1'b0; d1_clr = 1'b0;
    endtask

    task automatic step2(input logic v, input logic [7:0] w, input logic clr);
        d2_v = v; d2_i = w; d2_clr = clr;
        @(posedge clk); #1;
        d2_v = 1'b0; d2_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        seq[0] = 8'h80; seq[1] = 8'hC0; seq[2]  = 8'hE0; seq[3]  = 8'h70;
        seq[4] = 8'h38; seq[5] = 8'h9C; seq[6]  = 8'hCE; seq[7]  = 8'h67;
        seq[8] = 8'hB3; seq[9] = 8'hD9; seq[10] = 8'hEC; seq[11] = 8'hF6;
        d1_i = 8'h00; d1_v = 1'b0; d1_clr = 1'b0;
        d2_i = 8'h00; d2_v = 1'b0; d2_clr = 1'b0;

        // Reset state
        do_reset();
        check("rst_locked", 32'(d1_locked), 32'd0);
        check("rst_pulse",  32'(d1_pulse),  32'd0);
        check("rst_cnt",    32'(d1_cnt),    32'd0);
        check("rst_zd",     32'(d1_zd),     32'd0);
        check("rst_cnt2",   32'(d2_cnt),    32'd0);

        // Lock acquisition: 5 valid words, lock visible after the fifth
        for (int k = 0; k < 4; k++) step1(1'b1, seq[k], 1'b0);
        check("lock_pre", 32'(d1_locked), 32'd0);
        step1(1'b1, seq[4], 1'b0);
        check("lock_locked", 32'(d1_locked), 32'd1);
        check("lock_cnt",    32'(d1_cnt),    32'd0);
        check("lock_pulse",  32'(d1_pulse),  32'd0);

        // Single error, then the flywheel keeps the stream aligned
        step1(1'b1, 8'h1D, 1'b0);
        check("err1_pulse",  32'(d1_pulse),  32'd1);
        check("err1_cnt",    32'(d1_cnt),    32'd1);
        check("err1_locked", 32'(d1_locked), 32'd1);
        step1(1'b1, seq[6], 1'b0);
        check("fly_pulse",  32'(d1_pulse),  32'd0);
        check("fly_cnt",    32'(d1_cnt),    32'd1);
        step1(1'b1, seq[7], 1'b0);
        check("fly2_pulse", 32'(d1_pulse),  32'd0);
        check("fly2_locked", 32'(d1_locked), 32'd1);

        // Loss of lock after three consecutive misses, then fresh re-lock
        do_reset();
        for (int k = 0; k < 5; k++) step1(1'b1, seq[k], 1'b0);
        step1(1'b1, 8'h55, 1'b0);
        step1(1'b1, 8'h55, 1'b0);
        check("miss2_locked", 32'(d1_locked), 32'd1);
        step1(1'b1, 8'h55, 1'b0);
        check("miss3_locked", 32'(d1_locked), 32'd0);
        check("miss3_cnt",    32'(d1_cnt),    32'd3);
        check("miss3_pulse",  32'(d1_pulse),  32'd1);
        for (int k = 7; k < 11; k++) step1(1'b1, seq[k], 1'b0);
        check("relock_pre", 32'(d1_locked), 32'd0);
        step1(1'b1, seq[11], 1'b0);
        check("relock",     32'(d1_locked), 32'd1);
        check("relock_cnt", 32'(d1_cnt),    32'd3);

        // Non-zero mismatch in VERIFY re-seeds and restarts the match count
        do_reset();
        step1(1'b1, seq[0], 1'b0);
        step1(1'b1, seq[1], 1'b0);
        step1(1'b1, seq[0], 1'b0);
        for (int k = 1; k < 4; k++) step1(1'b1, seq[k], 1'b0);
        check("reseed_pre", 32'(d1_locked), 32'd0);
        step1(1'b1, seq[4], 1'b0);
        check("reseed_lock", 32'(d1_locked), 32'd1);

        // Zero lockup word
        do_reset();
        for (int k = 0; k < 4; k++) step1(1'b1, 8'h00, 1'b0);
        check("zero_zd",     32'(d1_zd),     32'd1);
        check("zero_locked", 32'(d1_locked), 32'd0);
        check("zero_cnt",    32'(d1_cnt),    32'd0);
        step1(1'b0, 8'h80, 1'b0);
        check("zero_hold",   32'(d1_zd),     32'd1);
        step1(1'b1, seq[0], 1'b0);
        check("zero_clear",  32'(d1_zd),     32'd0);
        for (int k = 1; k < 5; k++) step1(1'b1, seq[k], 1'b0);
        check("zero_lock",   32'(d1_locked), 32'd1);

        // Gaps are transparent; reset mid-lock clears everything
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) check("gap_pre", 32'(d1_locked), 32'd0);
            step1(1'b1, seq[k], 1'b0);
            step1(1'b0, 8'hA5, 1'b0);
        end
        check("gap_lock",  32'(d1_locked), 32'd1);
        check("gap_pulse", 32'(d1_pulse),  32'd0);
        step1(1'b1, 8'h00, 1'b0);
        check("pre_rst_pulse", 32'(d1_pulse), 32'd1);
        check("pre_rst_zd",    32'(d1_zd),    32'd1);
        check("pre_rst_cnt",   32'(d1_cnt),   32'd1);
        rst = 1'b1;
        step1(1'b1, seq[6], 1'b0);
        rst = 1'b0;
        check("midrst_locked", 32'(d1_locked), 32'd0);
        check("midrst_pulse",  32'(d1_pulse),  32'd0);
        check("midrst_cnt",    32'(d1_cnt),    32'd0);
        check("midrst_zd",     32'(d1_zd),     32'd0);

        // Narrow counter: wrap or saturate, then clear beats increment
        for (int k = 0; k < 5; k++) step2(1'b1, seq[k], 1'b0);
        check("sat_lock", 32'(d2_locked), 32'd1);
        for (int k = 0; k < 5; k++) begin
            step2(1'b1, 8'h55, 1'b0);
            check("sat_pulse", 32'(d2_pulse), 32'd1);
            if (k == 3) begin
`ifdef PRBS8_CHK_ERR_SAT_EN
                check("sat_cnt4", 32'(d2_cnt), 32'd3);
`else
                check("sat_cnt4", 32'(d2_cnt), 32'd0);
`endif
            end
        end
`ifdef PRBS8_CHK_ERR_SAT_EN
        check("sat_cnt5", 32'(d2_cnt), 32'd3);
`else
        check("sat_cnt5", 32'(d2_cnt), 32'd1);
`endif
        check("sat_locked", 32'(d2_locked), 32'd1);
        step2(1'b1, 8'h55, 1'b1);
        check("clr_cnt",   32'(d2_cnt),   32'd0);
        check("clr_pulse", 32'(d2_pulse), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
